// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, 16x oversampled with 3-sample majority; define UART_RX_PARITY_EN for 8E1 with Parity_err
module uart_byte_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] Baud_set,
  input  logic       uart_rx,
  output logic [7:0] Data,
  output logic       Rx_done,
  output logic       Frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       Parity_err,
`endif
  output logic       Rx_busy
);
  localparam int D0 = CLK_FREQ / (9600 * 16);
  localparam int D1 = CLK_FREQ / (19200 * 16);
  localparam int D2 = CLK_FREQ / (38400 * 16);
  localparam int D3 = CLK_FREQ / (57600 * 16);
  localparam int D4 = CLK_FREQ / (115200 * 16);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic rx_s, rx_d, fall, tick, maj, s7, s8;
  logic [2:0] baud_l, bit_idx;
  logic [15:0] div_cnt, div_m1;
  logic [3:0] tick_cnt;
  logic [7:0] shift_reg;
`ifdef UART_RX_PARITY_EN
  logic par;
`endif
  assign rx_s = sync[SYNC_STAGES-1];
  assign fall = rx_d & ~rx_s;
  assign div_m1 = baud_l == 3'd1 ? 16'(D1 - 1) :
                  baud_l == 3'd2 ? 16'(D2 - 1) :
                  baud_l == 3'd3 ? 16'(D3 - 1) :
                  baud_l == 3'd4 ? 16'(D4 - 1) : 16'(D0 - 1);
  assign tick = div_cnt == div_m1;
  // the third sample is the live one, so the vote resolves on tick 9 itself
  assign maj = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  // synchroniser, oversampling counters and frame FSM with registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      rx_d <= 1'b1;
      state <= IDLE;
      baud_l <= '0;
      div_cnt <= '0;
      tick_cnt <= '0;
      bit_idx <= '0;
      s7 <= 1'b0;
      s8 <= 1'b0;
      shift_reg <= '0;
      Data <= '0;
      Rx_done <= 1'b0;
      Frame_err <= 1'b0;
      Rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par <= 1'b0;
      Parity_err <= 1'b0;
`endif
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], uart_rx};
      rx_d <= rx_s;
      Rx_done <= 1'b0;
      Frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_err <= 1'b0;
`endif
      if (state == IDLE) begin
        if (fall) begin
          baud_l <= Baud_set;
          div_cnt <= '0;
          tick_cnt <= '0;
          bit_idx <= '0;
          Rx_busy <= 1'b1;
          state <= START;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 16'd1;
        if (tick) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd7) s7 <= rx_s;
          if (tick_cnt == 4'd8) s8 <= rx_s;
          if (tick_cnt == 4'd9) begin
            if (state == START && maj) begin
              state <= IDLE;
              Rx_busy <= 1'b0;
            end
            if (state == DATA) shift_reg[bit_idx] <= maj;
`ifdef UART_RX_PARITY_EN
            if (state == PARITY) par <= maj;
`endif
            if (state == STOP) begin
              state <= IDLE;
              Rx_busy <= 1'b0;
              if (!maj) Frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              else if (^{shift_reg, par}) Parity_err <= 1'b1;
`endif
              else begin
                Data <= shift_reg;
                Rx_done <= 1'b1;
              end
            end
          end
          if (tick_cnt == 4'd15) begin
            if (state == START) begin
              state <= DATA;
              bit_idx <= '0;
            end
            if (state == DATA) begin
              bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (bit_idx == 3'd7) state <= PARITY;
`else
              if (bit_idx == 3'd7) state <= STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY) state <= STOP;
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed bench for uart_byte_rx at 50 MHz
module tb_uart_byte_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] Baud_set = 3'd4;
  logic uart_rx = 1'b1;
  logic [7:0] Data;
  logic Rx_done, Frame_err, Rx_busy;
  int checks = 0, fails = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, both_cnt = 0, run = 0, max_run = 0;
  logic [7:0] rxq[$];
`ifdef UART_RX_PARITY_EN
  logic Parity_err;
`endif
  uart_byte_rx #(.CLK_FREQ(50000000), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .Baud_set(Baud_set),
    .uart_rx(uart_rx),
    .Data(Data),
    .Rx_done(Rx_done),
    .Frame_err(Frame_err),
`ifdef UART_RX_PARITY_EN
    .Parity_err(Parity_err),
`endif
    .Rx_busy(Rx_busy)
  );
  always #10 clk = ~clk;
  // pulse recorder, sampled mid-cycle
  always @(negedge clk) begin
    logic p;
`ifdef UART_RX_PARITY_EN
    p = Rx_done | Frame_err | Parity_err;
    if (Parity_err) perr_cnt++;
    if ((Rx_done && Parity_err) || (Frame_err && Parity_err)) both_cnt++;
`else
    p = Rx_done | Frame_err;
`endif
    if (Rx_done) begin
      done_cnt++;
      rxq.push_back(Data);
    end
    if (Frame_err) ferr_cnt++;
    if (Rx_done && Frame_err) both_cnt++;
    run = p ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input int bc, input logic stop, input logic par);
    uart_rx = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      wait_clks(bc);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = par;
    wait_clks(bc);
`else
    if (par === 1'bx) uart_rx = 1'b1;
`endif
    uart_rx = stop;
    wait_clks(bc);
  endtask
  task automatic send_ok(input logic [7:0] d, input int bc);
    send(d, bc, 1'b1, ^d);
  endtask
  initial begin
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
    check("rst_data", 32'(Data), 32'h00);
    check("rst_done", 32'(Rx_done), 32'h0);
    check("rst_ferr", 32'(Frame_err), 32'h0);
    check("rst_busy", 32'(Rx_busy), 32'h0);
    send_ok(8'h55, 432);
    wait_clks(5);
    check("b55_done", 32'(done_cnt), 32'd1);
    check("b55_data", 32'(Data), 32'h55);
    check("b55_ferr", 32'(ferr_cnt), 32'd0);
    check("b55_busy", 32'(Rx_busy), 32'h0);
    send_ok(8'h46, 432);
    send_ok(8'h55, 432);
    send_ok(8'h43, 432);
    send_ok(8'h4B, 432);
    wait_clks(10);
    check("b2b_done", 32'(done_cnt), 32'd5);
    check("b2b_q1", 32'(rxq[1]), 32'h46);
    check("b2b_q2", 32'(rxq[2]), 32'h55);
    check("b2b_q3", 32'(rxq[3]), 32'h43);
    check("b2b_q4", 32'(rxq[4]), 32'h4B);
    check("b2b_ferr", 32'(ferr_cnt), 32'd0);
    uart_rx = 1'b0;
    wait_clks(50);
    check("glitch_busy_hi", 32'(Rx_busy), 32'h1);
    wait_clks(50);
    uart_rx = 1'b1;
    wait_clks(432);
    check("glitch_busy_lo", 32'(Rx_busy), 32'h0);
    check("glitch_done", 32'(done_cnt), 32'd5);
    check("glitch_ferr", 32'(ferr_cnt), 32'd0);
    send(8'hA3, 432, 1'b0, ^8'hA3);
    uart_rx = 1'b0;
    wait_clks(20 * 432);
    check("brk_ferr", 32'(ferr_cnt), 32'd1);
    check("brk_done", 32'(done_cnt), 32'd5);
    check("brk_data", 32'(Data), 32'h4B);
    uart_rx = 1'b1;
    wait_clks(864);
    check("brk_ferr_once", 32'(ferr_cnt), 32'd1);
    send_ok(8'h0F, 432);
    wait_clks(10);
    check("b0f_done", 32'(done_cnt), 32'd6);
    check("b0f_data", 32'(Data), 32'h0F);
    Baud_set = 3'd0;
    uart_rx = 1'b0;
    wait_clks(5200);
    uart_rx = 1'b1;
    wait_clks(4 * 5200 + 2600);
    check("rst_mid_busy", 32'(Rx_busy), 32'h1);
    reset = 1'b1;
    wait_clks(1);
    reset = 1'b0;
    check("rst_mid_busy_lo", 32'(Rx_busy), 32'h0);
    check("rst_mid_data", 32'(Data), 32'h00);
    wait_clks(5200);
    check("rst_mid_done", 32'(done_cnt), 32'd6);
    check("rst_mid_ferr", 32'(ferr_cnt), 32'd1);
    check("rst_mid_data2", 32'(Data), 32'h00);
    Baud_set = 3'd2;
    send_ok(8'h3C, 1296);
    wait_clks(10);
    check("b3c_done", 32'(done_cnt), 32'd7);
    check("b3c_data", 32'(Data), 32'h3C);
    check("b3c_ferr", 32'(ferr_cnt), 32'd1);
`ifdef UART_RX_PARITY_EN
    Baud_set = 3'd4;
    send(8'h07, 432, 1'b1, 1'b1);
    wait_clks(10);
    check("par_ok_done", 32'(done_cnt), 32'd8);
    check("par_ok_data", 32'(Data), 32'h07);
    send(8'h00, 432, 1'b1, 1'b0);
    send(8'h07, 432, 1'b1, 1'b0);
    wait_clks(10);
    check("par_bad_perr", 32'(perr_cnt), 32'd1);
    check("par_bad_done", 32'(done_cnt), 32'd9);
    check("par_bad_data", 32'(Data), 32'h00);
`endif
    check("pulse_width", 32'(max_run), 32'd1);
    check("pulse_excl", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
